// File: rtl/hwpe_stream_tcdm_responder.sv
// Multi-channel TCDM slave: round-robin arbiter in front of a single-port word store.
// Optional random grant stalls are enabled with `define HWPE_TCDM_RESPONDER_STALL_EN.
module hwpe_stream_tcdm_responder #(
  parameter int unsigned NB_CHAN   = 2,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [NB_CHAN-1:0]       in_req_i,
  input  logic [NB_CHAN-1:0][31:0] in_add_i,
  input  logic [NB_CHAN-1:0]       in_wen_i,
  input  logic [NB_CHAN-1:0][3:0]  in_be_i,
  input  logic [NB_CHAN-1:0][31:0] in_data_i,
  output logic [NB_CHAN-1:0]       in_gnt_o,
  output logic [NB_CHAN-1:0][31:0] in_r_data_o,
  output logic [NB_CHAN-1:0]       in_r_valid_o,
  output logic [31:0]              nb_gnt_o
);

  localparam int unsigned PW = $clog2(NB_CHAN);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  // Handshake: a channel holds in_req_i (and its payload) until it sees in_gnt_o
  // in the same cycle; exactly one cycle after each grant that channel gets a
  // single-cycle in_r_valid_o with read data (or zero for writes).

  logic [31:0]   mem [MEM_WORDS];
  logic [PW-1:0] ptr_q, win, ptr_nxt;
  logic          found, gnt_en, stall;
  int unsigned   j;
  logic [AW-1:0] widx;
  logic          rv_q;
  logic [PW-1:0] rch_q;
  logic [31:0]   rdata_q;
  logic [31:0]   cnt_q;
  logic          unused_add;

  assign unused_add = ^in_add_i;

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) lfsr_q <= 16'hACE1;
    else                  lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // First requester at or after ptr wins, searching upward modulo NB_CHAN
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int unsigned i = 0; i < NB_CHAN; i++) begin
      j = (32'(ptr_q) + i) % NB_CHAN;
      if (!found && in_req_i[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
    gnt_en   = found && !rst_i && !clear_i && !stall;
    in_gnt_o = '0;
    if (gnt_en) in_gnt_o[win] = 1'b1;
  end

  assign ptr_nxt = (win == PW'(NB_CHAN - 1)) ? '0 : win + 1'b1;
  assign widx    = in_add_i[win][2 +: AW];

  // Store is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (gnt_en && !in_wen_i[win]) begin
      for (int b = 0; b < 4; b++) begin
        if (in_be_i[win][b]) mem[widx][8*b +: 8] <= in_data_i[win][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rch_q   <= '0;
      rdata_q <= '0;
    end else begin
      rv_q <= gnt_en;
      if (gnt_en) begin
        ptr_q   <= ptr_nxt;
        cnt_q   <= cnt_q + 32'd1;
        rch_q   <= win;
        rdata_q <= in_wen_i[win] ? mem[widx] : 32'h0;
      end
    end
  end

  // A reset or clear in the response cycle cancels that response outright
  always_comb begin
    in_r_valid_o = '0;
    in_r_data_o  = '0;
    if (rv_q && !rst_i && !clear_i) begin
      in_r_valid_o[rch_q] = 1'b1;
      in_r_data_o[rch_q]  = rdata_q;
    end
  end

  assign nb_gnt_o = cnt_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Scoreboard bench for hwpe_stream_tcdm_responder (NB_CHAN=4): directed vectors,
// expected responses queued at grant time and popped by an independent monitor.
module tb_hwpe_stream_tcdm_responder;

  logic             clk = 1'b0;
  logic             rst, clear;
  logic [3:0]       req, wen, gnt, r_valid;
  logic [3:0][31:0] add, wdata, r_data;
  logic [3:0][3:0]  be;
  logic [31:0]      nb_gnt;

  logic [33:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hwpe_stream_tcdm_responder #(.NB_CHAN(4), .MEM_WORDS(256)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_req_i(req), .in_add_i(add), .in_wen_i(wen), .in_be_i(be), .in_data_i(wdata),
    .in_gnt_o(gnt), .in_r_data_o(r_data), .in_r_valid_o(r_valid), .nb_gnt_o(nb_gnt)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [1:0] ch_of(logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: every presented response must match the head of the expected queue
  always @(negedge clk) begin
    logic [33:0] e;
    logic [31:0] others;
    if (r_valid != 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got %b expected none at %0t", r_valid, $time);
      end else begin
        e = exp_q.pop_front();
        others = '0;
        for (int c = 0; c < 4; c++) if (c != int'(e[33:32])) others |= r_data[c];
        check("rvalid_chan", 32'(r_valid), 32'(4'b0001 << e[33:32]));
        check("rdata", r_data[e[33:32]], e[31:0]);
        check("rdata_others_zero", others, 32'h0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
    add[ch] = a; wen[ch] = w; be[ch] = b; wdata[ch] = d;
  endtask

  // One cycle of requests; expected winner and its response are queued
  task automatic step(input logic [3:0] r, input logic [3:0] exp_gnt,
                      input logic [31:0] exp_rd, input string name);
    req = r;
    @(negedge clk);
    check(name, 32'(gnt), 32'(exp_gnt));
    if (exp_gnt != 4'b0) exp_q.push_back({ch_of(exp_gnt), exp_rd});
    @(posedge clk);
    #1 req = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; req = '1; wen = '1; add = '0; be = '0; wdata = '0;
    @(negedge clk);
    check("gnt_during_reset", 32'(gnt), 32'h0);
    @(posedge clk);
    #1 req = '0;
    do_reset();
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_rvalid", 32'(r_valid), 32'h0);
    check("reset_rdata", r_data[0] | r_data[1] | r_data[2] | r_data[3], 32'h0);
    check("reset_nb_gnt", nb_gnt, 32'h0);
    @(posedge clk);
    #1;

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
    begin
      logic [15:0] l;
      logic        g;
      int          n;
      do_reset();
      l = 16'hACE1;
      n = 0;
      set_ch(0, 32'h40, 1'b0, 4'hF, 32'h0BADF00D);
      for (int k = 0; k < 64; k++) begin
        g = (l[1:0] != 2'b00);
        step(4'b0001, g ? 4'b0001 : 4'b0000, 32'h0, "stall_gnt");
        if (g) n++;
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      step(4'b0000, 4'b0000, 32'h0, "stall_idle");
      check("stall_nb_gnt", nb_gnt, 32'(n));
    end
`else
    // Write then immediate read-back of the same word
    set_ch(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    step(4'b0001, 4'b0001, 32'h0, "w_full_gnt");
    set_ch(0, 32'h10, 1'b1, 4'hF, 32'h0);
    step(4'b0001, 4'b0001, 32'hDEADBEEF, "r_full_gnt");
    step(4'b0000, 4'b0000, 32'h0, "idle_a");
    check("nb_gnt_2", nb_gnt, 32'd2);

    // Partial byte-enable write (bytes 0 and 2), then read and aliased read
    set_ch(1, 32'h20, 1'b0, 4'hF, 32'h11223344);
    step(4'b0010, 4'b0010, 32'h0, "w_base_gnt");
    set_ch(1, 32'h20, 1'b0, 4'b0101, 32'hAABBCCDD);
    step(4'b0010, 4'b0010, 32'h0, "w_be_gnt");
    set_ch(1, 32'h20, 1'b1, 4'hF, 32'h0);
    step(4'b0010, 4'b0010, 32'h11BB33DD, "r_be_gnt");
    set_ch(1, 32'hF000_0423, 1'b1, 4'hF, 32'h0);
    step(4'b0010, 4'b0010, 32'h11BB33DD, "r_alias_gnt");
    step(4'b0000, 4'b0000, 32'h0, "idle_b");
    check("nb_gnt_6", nb_gnt, 32'd6);

    // All four channels requesting: strict rotation
    do_reset();
    check("nb_gnt_after_reset", nb_gnt, 32'h0);
    for (int c = 0; c < 4; c++) set_ch(c, 32'h10, 1'b1, 4'hF, 32'h0);
    for (int k = 0; k < 8; k++)
      step(4'b1111, 4'b0001 << (k % 4), 32'hDEADBEEF, "rr_all_gnt");
    step(4'b0000, 4'b0000, 32'h0, "idle_c");
    check("nb_gnt_8", nb_gnt, 32'd8);

    // ptr moved to 3 via a lone ch2 grant, then ch1/ch2 compete
    set_ch(2, 32'h20, 1'b1, 4'hF, 32'h0);
    step(4'b0100, 4'b0100, 32'h11BB33DD, "rr_ptr3_setup");
    step(4'b0110, 4'b0010, 32'hDEADBEEF, "rr_ptr3_first");
    step(4'b0110, 4'b0100, 32'h11BB33DD, "rr_ptr3_second");
    step(4'b0110, 4'b0010, 32'hDEADBEEF, "rr_ptr3_third");
    step(4'b0000, 4'b0000, 32'h0, "idle_d");
    check("nb_gnt_12", nb_gnt, 32'd12);

    // Clear in the response cycle: response dropped, counters and ptr zeroed
    req = 4'b0001;
    @(negedge clk);
    check("clr_read_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1 req = 4'b0010; clear = 1'b1;
    @(negedge clk);
    check("clr_gnt_suppressed", 32'(gnt), 32'h0);
    check("clr_rvalid_dropped", 32'(r_valid), 32'h0);
    @(posedge clk);
    #1 req = '0; clear = 1'b0;
    check("clr_nb_gnt", nb_gnt, 32'h0);
    step(4'b0011, 4'b0001, 32'hDEADBEEF, "clr_ptr0_readback");
    step(4'b0000, 4'b0000, 32'h0, "idle_e");
    check("nb_gnt_1", nb_gnt, 32'd1);

    // Reset in the response cycle cancels it
    req = 4'b0100;
    @(negedge clk);
    check("rst_read_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1 req = '0; rst = 1'b1;
    @(negedge clk);
    check("rst_rvalid_dropped", 32'(r_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_nb_gnt", nb_gnt, 32'h0);
    step(4'b0000, 4'b0000, 32'h0, "idle_f");
`endif

    step(4'b0000, 4'b0000, 32'h0, "idle_end");
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
